// File: rtl/uart_frame_tx_if.sv
// ---------------------------------------------------------------------------
// uart_frame_tx_if
// Bundles the signals of the response-frame transmitter. It carries two groups:
// the frame-producer side (payload buffer writes, send/resend, status pulses)
// and the byte-level handshake with the UART TX serializer.
//
// Modports
//   master : the environment around the transmitter. It drives the producer
//            inputs and the UART engine's tx_busy/tx_done.
//   slave  : the transmitter itself.
//
// Signals
//   wr_en, wr_addr, wr_data   payload buffer write port
//   send, cmd, len            start a new frame
//   resend                    replay the last accepted frame
//   tx_data, tx_start         byte handed to the UART TX engine
//   tx_busy, tx_done          UART TX engine status
//   busy, frame_done, err     frame status toward the producer
// ---------------------------------------------------------------------------
interface uart_frame_tx_if #(
    parameter int MAX_N = 8
);
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int LW = $clog2(MAX_N + 1);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          send;
    logic [7:0]    cmd;
    logic [LW-1:0] len;
    logic          resend;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy;
    logic          tx_done;
    logic          busy;
    logic          frame_done;
    logic          err;

    modport master (
        output wr_en, wr_addr, wr_data, send, cmd, len, resend, tx_busy, tx_done,
        input  tx_data, tx_start, busy, frame_done, err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, send, cmd, len, resend, tx_busy, tx_done,
        output tx_data, tx_start, busy, frame_done, err
    );
endinterface

// File: rtl/uart_frame_tx.sv
// ---------------------------------------------------------------------------
// uart_frame_tx
// Response-frame transmitter for the FE/L/CMD/payload/EF UART command protocol.
// It serializes one frame byte by byte into the UART TX byte engine:
//   SOF, L (= len + 2), CMD, len payload bytes, EOF.
// The last accepted frame (cmd, len and payload buffer) is retained, so a
// resend request replays it unchanged.
//
// Ports
//   clk   system clock, all logic on the rising edge
//   rst   synchronous reset, active high
//   bus   uart_frame_tx_if.slave (see the interface file for the signal list)
//
// The MAX_N of the connected interface instance must equal this module's
// MAX_N, because the interface sets the wr_addr and len widths.
// ---------------------------------------------------------------------------
module uart_frame_tx #(
    parameter int         MAX_N    = 8,
    parameter logic [7:0] SOF_BYTE = 8'hFE,
    parameter logic [7:0] EOF_BYTE = 8'hEF
) (
    input  logic           clk,
    input  logic           rst,
    uart_frame_tx_if.slave bus
);
    localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
    localparam int LW = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_LEN,
        S_CMD,
        S_DATA,
        S_EOF
    } state_t;

    // Every byte-sending state first issues its byte (ISSUE) and then waits
    // for the UART engine to finish shifting it out (WAIT).
    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_t;

    state_t        state_q, state_d;
    phase_t        phase_q, phase_d;
    logic [LW-1:0] idx_q, idx_d;
    logic [7:0]    cmd_q;
    logic [LW-1:0] len_q;
    logic          valid_q;
    logic [7:0]    buf_mem [MAX_N];

    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          err_q, err_d;

    logic          len_ok;
    logic          start_new;
    logic          start_replay;
    logic          reject;
    logic          last_data;
    logic          issue_now;
    logic [7:0]    byte_cur;

    // Accept decisions happen only in IDLE. send takes priority over resend,
    // and an oversized send is rejected without touching the stored frame.
    assign len_ok       = (bus.len <= LW'(MAX_N));
    assign start_new    = (state_q == S_IDLE) && bus.send && len_ok;
    assign reject       = (state_q == S_IDLE) && bus.send && !len_ok;
    assign start_replay = (state_q == S_IDLE) && !bus.send && bus.resend && valid_q;

    assign last_data = ((idx_q + LW'(1)) == len_q);
    assign issue_now = (state_q != S_IDLE) && (phase_q == PH_ISSUE) && !bus.tx_busy;

    // Payload buffer. It is frozen while a frame is in flight, so a replay
    // sends exactly what the original frame sent. It is deliberately not reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && (state_q == S_IDLE) && (int'(bus.wr_addr) < MAX_N)) begin
            buf_mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // State register, latched frame descriptor and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_ISSUE;
            idx_q        <= '0;
            cmd_q        <= '0;
            len_q        <= '0;
            valid_q      <= 1'b0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            if (start_new) begin
                cmd_q   <= bus.cmd;
                len_q   <= bus.len;
                valid_q <= 1'b1;
            end
        end
    end

    // Next-state logic. A tx_done that arrives during ISSUE is ignored,
    // because the byte of the current state has not been handed over yet.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        if (state_q == S_IDLE) begin
            if (start_new || start_replay) begin
                state_d = S_SOF;
                phase_d = PH_ISSUE;
                idx_d   = '0;
            end
        end else if (phase_q == PH_ISSUE) begin
            if (!bus.tx_busy) begin
                phase_d = PH_WAIT;
            end
        end else if (bus.tx_done) begin
            phase_d = PH_ISSUE;
            case (state_q)
                S_SOF:   state_d = S_LEN;
                S_LEN:   state_d = S_CMD;
                S_CMD:   state_d = (len_q == '0) ? S_EOF : S_DATA;
                S_DATA: begin
                    if (last_data) begin
                        state_d = S_EOF;
                    end else begin
                        idx_d = idx_q + LW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic: computes the next values of the registered outputs.
    // tx_data is held between issues, so it stays stable until tx_done arrives.
    always_comb begin
        byte_cur = '0;
        case (state_q)
            S_SOF:   byte_cur = SOF_BYTE;
            S_LEN:   byte_cur = 8'(len_q) + 8'd2;
            S_CMD:   byte_cur = cmd_q;
            S_DATA:  byte_cur = buf_mem[idx_q[AW-1:0]];
            S_EOF:   byte_cur = EOF_BYTE;
            default: byte_cur = '0;
        endcase

        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        frame_done_d = 1'b0;
        err_d        = reject;
        busy_d       = (state_d != S_IDLE);
        if (issue_now) begin
            tx_start_d = 1'b1;
            tx_data_d  = byte_cur;
        end
        if ((state_q == S_EOF) && (phase_q == PH_WAIT) && bus.tx_done) begin
            frame_done_d = 1'b1;
        end
    end

    assign bus.tx_data    = tx_data_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_tx
// Directed testbench for uart_frame_tx. A small UART TX engine model answers
// each tx_start with tx_busy and a tx_done pulse about 10 cycles later. A
// monitor records every byte issued so each frame can be compared against a
// hand-computed byte list.
// ---------------------------------------------------------------------------
module tb_uart_frame_tx;
    localparam int MAX_N = 8;

    logic clk = 1'b0;
    logic rst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_frame_tx_if #(.MAX_N(MAX_N)) bus ();

    uart_frame_tx #(
        .MAX_N   (MAX_N),
        .SOF_BYTE(8'hFE),
        .EOF_BYTE(8'hEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // UART TX engine model plus manual overrides for the busy-hold test.
    logic model_busy = 1'b0;
    logic model_done = 1'b0;
    int   model_cnt  = 0;
    logic hold_busy  = 1'b0;
    logic inj_done   = 1'b0;

    assign bus.tx_busy = model_busy | hold_busy;
    assign bus.tx_done = model_done | inj_done;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (bus.tx_start === 1'b1) begin
            model_busy <= 1'b1;
            model_cnt  <= 10;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) begin
                model_busy <= 1'b0;
                model_done <= 1'b1;
            end
        end
    end

    // Byte and frame_done monitor.
    logic [7:0] byte_q[$];
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (bus.tx_start === 1'b1) byte_q.push_back(bus.tx_data);
        if (bus.frame_done === 1'b1) done_cnt++;
    end

    logic [7:0] exp_bytes[$];

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r, input logic [7:0] c,
                                  input logic [3:0] l);
        bus.send   = s;
        bus.resend = r;
        bus.cmd    = c;
        bus.len    = l;
        @(negedge clk);
        bus.send   = 1'b0;
        bus.resend = 1'b0;
    endtask

    task automatic write_buf(input logic [2:0] a, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_frame_done(input string tag, input int budget);
        int n = 0;
        while (bus.frame_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " frame_done"}, 32'(bus.frame_done), 32'd1);
        check_output({tag, " busy at frame_done"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int n = 0;
        while (byte_q.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output({tag, " byte count reached"}, 32'(byte_q.size() >= target), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int base, input int done_base);
        check_output({tag, " tx_start count"}, 32'(byte_q.size() - base), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++) begin
            logic [31:0] obs;
            obs = (base + i < byte_q.size()) ? 32'(byte_q[base + i]) : 32'hFFFF_FFFF;
            check_output($sformatf("%s byte%0d", tag, i), obs, 32'(exp_bytes[i]));
        end
        check_output({tag, " frame_done count"}, 32'(done_cnt - done_base), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int dbase;

        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.send    = 1'b0;
        bus.resend  = 1'b0;
        bus.cmd     = '0;
        bus.len     = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check_output("reset tx_start", 32'(bus.tx_start), 32'd0);
        check_output("reset tx_data", 32'(bus.tx_data), 32'd0);
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset frame_done", 32'(bus.frame_done), 32'd0);
        check_output("reset err", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Resend before any frame was accepted has nothing to replay.
        apply_stimulus(1'b0, 1'b1, 8'h00, 4'd0);
        check_output("early resend busy", 32'(bus.busy), 32'd0);

        // Test 1: three-byte payload, write ignored while busy.
        $display("[TB] test 1: cmd 01 len 3");
        write_buf(3'd0, 8'h11);
        write_buf(3'd1, 8'h22);
        write_buf(3'd2, 8'h33);
        base  = byte_q.size();
        dbase = done_cnt;
        apply_stimulus(1'b1, 1'b0, 8'h01, 4'd3);
        check_output("t1 busy after accept", 32'(bus.busy), 32'd1);
        check_output("t1 no tx_start at t+1", 32'(bus.tx_start), 32'd0);
        @(negedge clk);
        check_output("t1 tx_start at t+2", 32'(bus.tx_start), 32'd1);
        check_output("t1 tx_data SOF", 32'(bus.tx_data), 32'hFE);
        write_buf(3'd0, 8'hAA);
        wait_frame_done("t1", 300);
        exp_bytes = '{8'hFE, 8'h05, 8'h01, 8'h11, 8'h22, 8'h33, 8'hEF};
        check_frame("t1", base, dbase);

        // Test 3: resend replays the identical frame.
        $display("[TB] test 3: resend");
        base  = byte_q.size();
        dbase = done_cnt;
        apply_stimulus(1'b0, 1'b1, 8'h00, 4'd0);
        check_output("t3 busy after resend", 32'(bus.busy), 32'd1);
        wait_frame_done("t3", 300);
        check_frame("t3", base, dbase);

        // Test 4: oversized length is rejected; the stored frame survives.
        $display("[TB] test 4: len 9 rejected");
        base = byte_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h77, 4'd9);
        check_output("t4 err pulse", 32'(bus.err), 32'd1);
        check_output("t4 busy stays low", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_output("t4 err one cycle", 32'(bus.err), 32'd0);
        repeat (5) @(negedge clk);
        check_output("t4 no tx_start", 32'(byte_q.size() - base), 32'd0);
        dbase = done_cnt;
        apply_stimulus(1'b0, 1'b1, 8'h00, 4'd0);
        wait_frame_done("t4 replay", 300);
        check_frame("t4 replay", base, dbase);

        // Test 2: empty payload.
        $display("[TB] test 2: cmd 02 len 0");
        base  = byte_q.size();
        dbase = done_cnt;
        apply_stimulus(1'b1, 1'b0, 8'h02, 4'd0);
        wait_frame_done("t2", 200);
        exp_bytes = '{8'hFE, 8'h02, 8'h02, 8'hEF};
        check_frame("t2", base, dbase);

        // send and resend together: send wins. A send while busy is dropped.
        $display("[TB] send wins over resend, send while busy ignored");
        base  = byte_q.size();
        dbase = done_cnt;
        apply_stimulus(1'b1, 1'b1, 8'h03, 4'd1);
        repeat (3) @(negedge clk);
        apply_stimulus(1'b1, 1'b0, 8'h09, 4'd2);
        wait_frame_done("sw", 200);
        exp_bytes = '{8'hFE, 8'h03, 8'h03, 8'h11, 8'hEF};
        check_frame("sw", base, dbase);
        repeat (20) @(negedge clk);
        check_output("sw no queued frame", 32'(byte_q.size() - base), 32'd5);
        check_output("sw idle after", 32'(bus.busy), 32'd0);

        // Test 5: tx_busy held high in CMD, with a spurious tx_done in ISSUE.
        $display("[TB] test 5: tx_busy hold during CMD");
        base  = byte_q.size();
        dbase = done_cnt;
        apply_stimulus(1'b1, 1'b0, 8'h05, 4'd2);
        wait_bytes("t5 LEN issued", base + 2, 100);
        hold_busy = 1'b1;
        repeat (20) @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        repeat (12) @(negedge clk);
        check_output("t5 no tx_start while held", 32'(byte_q.size() - base), 32'd2);
        check_output("t5 tx_data stable", 32'(bus.tx_data), 32'h04);
        check_output("t5 busy while held", 32'(bus.busy), 32'd1);
        hold_busy = 1'b0;
        wait_frame_done("t5", 300);
        exp_bytes = '{8'hFE, 8'h04, 8'h05, 8'h11, 8'h22, 8'hEF};
        check_frame("t5", base, dbase);

        // Test 6: reset in the middle of DATA byte 2 aborts and clears valid.
        $display("[TB] test 6: reset mid-frame");
        base = byte_q.size();
        apply_stimulus(1'b1, 1'b0, 8'h06, 4'd3);
        wait_bytes("t6 DATA byte 2 issued", base + 5, 200);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("t6 tx_start after rst", 32'(bus.tx_start), 32'd0);
        check_output("t6 tx_data after rst", 32'(bus.tx_data), 32'd0);
        check_output("t6 busy after rst", 32'(bus.busy), 32'd0);
        check_output("t6 frame_done after rst", 32'(bus.frame_done), 32'd0);
        check_output("t6 err after rst", 32'(bus.err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b0, 1'b1, 8'h00, 4'd0);
        check_output("t6 resend ignored busy", 32'(bus.busy), 32'd0);
        repeat (30) @(negedge clk);
        check_output("t6 no bytes after rst", 32'(byte_q.size() - base), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
